seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/div_step.sv | 21 ++
 rtl/seq_div.sv | 129 ++++++++++++
 tb/tb_seq_div.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential signed divider: default width and FSM encoding.
package seq_div_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH:0]   dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;

  assign shifted  = {rem, in_bit};
  assign q_bit    = (shifted >= dsr);
  // rem < dsr always holds, so a successful subtraction fits back in WIDTH bits
  assign sub      = WIDTH'(shifted - dsr);
  assign rem_next = q_bit ? sub : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_div.sv
// Sequential signed divider: WIDTH restoring steps on magnitudes, then sign fix-up.
// The FIX state is the one-cycle done window; a new start is accepted there as well as in IDLE.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nx;
  logic   accept, last_step;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd;
  logic [WIDTH:0]   dsr;
  logic             sx, sy, ovf_pend;

  logic [WIDTH:0]   x_ext, y_ext, abs_y;
  logic [WIDTH-1:0] abs_x;
  logic             y_zero, ovf_case;

  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic             q_bit;

  assign x_ext    = {X[WIDTH-1], X};
  assign y_ext    = {Y[WIDTH-1], Y};
  // |most-negative| = 2^(WIDTH-1) still fits in WIDTH unsigned bits
  assign abs_x    = WIDTH'(X[WIDTH-1] ? -x_ext : x_ext);
  assign abs_y    = Y[WIDTH-1] ? -y_ext : y_ext;
  assign y_zero   = (Y == '0);
  assign ovf_case = (X == {1'b1, {(WIDTH-1){1'b0}}}) && (&Y);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .in_bit   (dvd[WIDTH-1]),
    .dsr      (dsr),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  assign dvd_nx = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE, FIX: begin
        done = (state == FIX);
        if (start) begin
          accept   = 1'b1;
          state_nx = y_zero ? FIX : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_nx  = FIX;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      ovf_pend    <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      sx       <= X[WIDTH-1];
      sy       <= Y[WIDTH-1];
      dvd      <= abs_x;
      dsr      <= abs_y;
      rem      <= '0;
      cnt      <= '0;
      ovf_pend <= ovf_case;
      // divide-by-zero skips the iterations and publishes immediately
      if (y_zero) begin
        Q           <= '1;
        R           <= X;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end
    end else if (state == CALC) begin
      rem <= rem_nx;
      dvd <= dvd_nx;
      cnt <= cnt + 1'b1;
      if (last_step) begin
        Q           <= (sx ^ sy) ? -dvd_nx : dvd_nx;
        R           <= sx ? -rem_nx : rem_nx;
        div_by_zero <= 1'b0;
        overflow    <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed corner cases, back-to-back, reset abort, random ops and a full sweep.
module tb_seq_div;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] Q, R;

  int checks = 0;
  int failures = 0;
  int cur_x = 0;
  int cur_y = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .X           (X),
    .Y           (Y),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s x=%0d y=%0d observed=%0h expected=%0h", tag, cur_x, cur_y, obs, exp);
    end
  endtask

  // Signed truncating division with the block's special cases.
  function automatic void model(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dbz, output logic ovf);
    int xi, yi;
    xi  = x;
    yi  = y;
    dbz = 1'b0;
    ovf = 1'b0;
    if (yi == 0) begin
      q   = '1;
      r   = x;
      dbz = 1'b1;
    end else if (xi == -(1 << (W - 1)) && yi == -1) begin
      q   = W'(xi);
      r   = '0;
      ovf = 1'b1;
    end else begin
      q = W'(xi / yi);
      r = W'(xi % yi);
    end
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eq, er;
    logic         ed, eo;
    int           n, elat;
    model(x, y, eq, er, ed, eo);
    elat  = ed ? 1 : W + 1;
    cur_x = int'($signed(x));
    cur_y = int'($signed(y));
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done) begin
        // garbage on the inputs while busy must not disturb the running operation
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        X = W'($urandom);
        Y = W'($urandom);
      end
    end while (!done && n < 20);
    start = 1'b0;
    chk("latency", n, elat);
    chk("busy_at_done", busy, 1'b0);
    chk("Q", Q, eq);
    chk("R", R, er);
    chk("div_by_zero", div_by_zero, ed);
    chk("overflow", overflow, eo);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("Q_hold", Q, eq);
    chk("flags_hold", {div_by_zero, overflow}, {ed, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, ndone;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_Q", Q, '0);
    chk("rst_R", R, '0);
    chk("rst_flags", {div_by_zero, overflow}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed examples
    run_op(4'd7, 4'd2);
    run_op(4'hA, 4'd3);
    run_op(4'd7, 4'hE);
    run_op(4'h8, 4'hF);
    run_op(4'd5, 4'd0);
    run_op(4'hF, 4'd0);
    run_op(4'h9, 4'd2);

    // start held high: accepts on every done cycle, mid-operation X changes ignored
    cur_x = 6; cur_y = 3;
    dn = 0;
    @(negedge clk);
    Y = 4'd3;
    for (int c = 0; c < 20; c++) begin
      start = (c < 12);
      X = (c % 5 == 0) ? 4'd6 : W'($urandom);
      @(posedge clk); #1;
      if (done) begin
        dn++;
        chk("b2b_done_cycle", c, 5 * dn - 1);
        chk("b2b_Q", Q, 4'd2);
        chk("b2b_R", R, 4'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_done_count", dn, 3);

    // reset two cycles into an operation
    run_op(4'h9, 4'd2);
    cur_x = 7; cur_y = 3;
    @(negedge clk);
    X = 4'd7; Y = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_Q", Q, '0);
    chk("abort_R", R, '0);
    chk("abort_flags", {div_by_zero, overflow}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(4'hA, 4'd4);

    // random operations
    for (int i = 0; i < 40; i++) run_op(W'($urandom), W'($urandom));

    // full sweep of every operand pair
    for (int i = 0; i < 256; i++) run_op(W'(i >> 4), W'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
